// File: rtl/isq_age_select.sv
// -----------------------------------------------------------------------------
// isq_age_select
//
// Allocation and oldest-first issue selector for one issue queue. It sits next
// to the array of age_buffer_entry instances: it hands out free slots to the
// upstream allocator (driving each entry's wr_en), watches every entry's
// ready_to_dequeue_out, selects the oldest ready entry onto a registered
// valid/ready issue port and drives that entry's clear_entry when it issues.
//
// Optional feature macro: ISQ_AGE_SELECT_OLDEST_EN
//   defined     : a DEPTH x DEPTH age matrix is kept and the oldest ready
//                 entry wins selection.
//   not defined : no age matrix; the lowest-index ready entry wins. All other
//                 behaviour and timing are identical.
//
// Ports
//   clock        in   sole clock, rising edge
//   reset        in   synchronous, active-high reset
//   enq_valid    in   allocate one entry this cycle
//   enq_ready    out  a free slot exists (and no reset/flush)
//   enq_idx      out  lowest-index free slot
//   entry_wr_en  out  one-hot write enable of the allocated slot
//   entry_ready  in   per-entry ready_to_dequeue_out
//   entry_clear  out  per-entry clear_entry (issue or flush)
//   issue_valid  out  registered: an entry is presented
//   issue_idx    out  registered: index of the presented entry
//   issue_ready  in   downstream accepts the presented entry
//   flush        in   discard every entry and any pending issue
//   occupancy    out  registered count of allocated slots
// -----------------------------------------------------------------------------
module isq_age_select #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    output logic [IDX_W-1:0]             enq_idx,
    output logic [DEPTH-1:0]             entry_wr_en,
    input  logic [DEPTH-1:0]             entry_ready,
    output logic [DEPTH-1:0]             entry_clear,
    output logic                         issue_valid,
    output logic [IDX_W-1:0]             issue_idx,
    input  logic                         issue_ready,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [DEPTH-1:0] ONE = {{(DEPTH-1){1'b0}}, 1'b1};

    // State
    logic [DEPTH-1:0] occ_q, occ_d;
    logic             issue_valid_q, issue_valid_d;
    logic [IDX_W-1:0] issue_idx_q, issue_idx_d;
    logic [OCC_W-1:0] occupancy_q, occupancy_d;

    // Combinational helpers
    logic             enq_fire;
    logic             issue_fire;
    logic [DEPTH-1:0] hold;
    logic [DEPTH-1:0] cand;
    logic [IDX_W-1:0] win_idx;

    // -------------------------------------------------------------------------
    // Allocation side
    // -------------------------------------------------------------------------
    // Scan from the top so the last assignment is the lowest free index.
    always_comb begin
        enq_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!occ_q[i]) begin
                enq_idx = i[IDX_W-1:0];
            end
        end
    end

    // Full is judged on registered occupancy bits, so a slot freed by an issue
    // this cycle is only offered from the next cycle on.
    assign enq_ready   = !reset && !flush && !(&occ_q);
    assign enq_fire    = enq_valid && enq_ready;
    assign entry_wr_en = enq_fire ? (ONE << enq_idx) : '0;

    // -------------------------------------------------------------------------
    // Issue side
    // -------------------------------------------------------------------------
    assign issue_fire = issue_valid_q && issue_ready && !flush && !reset;

    // The presented entry stays occupied until it is accepted; masking it out
    // keeps it from being picked a second time.
    assign hold = issue_valid_q ? (ONE << issue_idx_q) : '0;
    assign cand = entry_ready & occ_q & ~hold;

    always_comb begin
        entry_clear = '0;
        if (reset) begin
            entry_clear = '0;
        end else if (flush) begin
            entry_clear = '1;
        end else if (issue_fire) begin
            entry_clear = hold;
        end
    end

`ifdef ISQ_AGE_SELECT_OLDEST_EN
    // age_q[i][j] = 1 when slot i is older than slot j.
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];
    logic             older_seen;
    logic             win_found;

    // A candidate wins when no other candidate is older than it. The age
    // relation is a strict total order over allocated slots, so exactly one
    // candidate survives whenever cand is non-zero.
    always_comb begin
        win_idx    = '0;
        win_found  = 1'b0;
        older_seen = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            older_seen = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && cand[j] && age_q[j][i]) begin
                    older_seen = 1'b1;
                end
            end
            if (cand[i] && !older_seen && !win_found) begin
                win_idx   = i[IDX_W-1:0];
                win_found = 1'b1;
            end
        end
    end

    // A newly allocated slot is younger than every slot already allocated.
    // Rows/columns of free slots are left stale; they are rewritten here on
    // the next allocation before they can matter.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_d[i] = age_q[i];
        end
        if (enq_fire) begin
            for (int j = 0; j < DEPTH; j++) begin
                age_d[enq_idx][j] = 1'b0;
                age_d[j][enq_idx] = occ_q[j];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end
`else
    // Without the age matrix the lowest-index candidate wins.
    always_comb begin
        win_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_idx = i[IDX_W-1:0];
            end
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        occ_d         = occ_q;
        issue_valid_d = issue_valid_q;
        issue_idx_d   = issue_idx_q;
        occupancy_d   = occupancy_q;
        if (flush) begin
            occ_d         = '0;
            issue_valid_d = 1'b0;
            occupancy_d   = '0;
        end else begin
            if (issue_fire) begin
                occ_d[issue_idx_q] = 1'b0;
            end
            // The enqueued slot is free in occ_q, so it never collides with
            // the slot being issued.
            if (enq_fire) begin
                occ_d[enq_idx] = 1'b1;
            end
            // Reload only when nothing is presented or it is being accepted;
            // otherwise the presented entry stays put even if an older one
            // becomes ready.
            if (!issue_valid_q || issue_ready) begin
                issue_valid_d = |cand;
                issue_idx_d   = win_idx;
            end
            occupancy_d = occupancy_q + OCC_W'(enq_fire) - OCC_W'(issue_fire);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            occ_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
            occupancy_q   <= '0;
        end else begin
            occ_q         <= occ_d;
            issue_valid_q <= issue_valid_d;
            issue_idx_q   <= issue_idx_d;
            occupancy_q   <= occupancy_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_idx   = issue_idx_q;
    assign occupancy   = occupancy_q;

endmodule

// File: tb/tb_isq_age_select.sv
// -----------------------------------------------------------------------------
// tb_isq_age_select
//
// Directed bench for isq_age_select (DEPTH = 8). The stimulus thread pushes the
// index it expects to issue into a queue; a separate monitor pops and compares
// on every accepted issue (issue_idx and the matching entry_clear one-hot).
// The stimulus thread also compares allocation, occupancy and flush outputs.
// -----------------------------------------------------------------------------
module tb_isq_age_select;

    localparam int DEPTH = 8;
    localparam int IDX_W = 3;
    localparam int OCC_W = 4;

    logic             clock;
    logic             reset;
    logic             enq_valid;
    logic             enq_ready;
    logic [IDX_W-1:0] enq_idx;
    logic [DEPTH-1:0] entry_wr_en;
    logic [DEPTH-1:0] entry_ready;
    logic [DEPTH-1:0] entry_clear;
    logic             issue_valid;
    logic [IDX_W-1:0] issue_idx;
    logic             issue_ready;
    logic             flush;
    logic [OCC_W-1:0] occupancy;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    isq_age_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .enq_valid   (enq_valid),
        .enq_ready   (enq_ready),
        .enq_idx     (enq_idx),
        .entry_wr_en (entry_wr_en),
        .entry_ready (entry_ready),
        .entry_clear (entry_clear),
        .issue_valid (issue_valid),
        .issue_idx   (issue_idx),
        .issue_ready (issue_ready),
        .flush       (flush),
        .occupancy   (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    // Scoreboard monitor: every accepted issue must match the next expected index.
    always @(negedge clock) begin
        if (!reset && !flush && issue_valid && issue_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue actual=%0d required=none", issue_idx);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("issue_idx", 32'(issue_idx), 32'(e));
                check("issue_clear", 32'(entry_clear), 32'(1) << e);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        enq_valid   = 1'b1;
        entry_ready = '0;
        issue_ready = 1'b0;
        flush       = 1'b0;

        // Reset: nothing allocated, requests ignored.
        repeat (2) tick();
        at_neg();
        check("rst_enq_ready", 32'(enq_ready), 0);
        check("rst_wr_en", 32'(entry_wr_en), 0);
        check("rst_clear", 32'(entry_clear), 0);
        check("rst_issue_valid", 32'(issue_valid), 0);
        check("rst_issue_idx", 32'(issue_idx), 0);
        check("rst_occupancy", 32'(occupancy), 0);
        tick();
        reset     = 1'b0;
        enq_valid = 1'b0;
        at_neg();
        check("post_rst_enq_ready", 32'(enq_ready), 1);
        check("post_rst_enq_idx", 32'(enq_idx), 0);

        // Fill all 8 slots in index order.
        tick();
        enq_valid = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            at_neg();
            check("fill_enq_idx", 32'(enq_idx), 32'(k));
            check("fill_wr_en", 32'(entry_wr_en), 32'(1) << k);
            check("fill_occupancy", 32'(occupancy), 32'(k));
            tick();
        end
        at_neg();
        check("full_occupancy", 32'(occupancy), 8);
        check("full_enq_ready", 32'(enq_ready), 0);
        check("full_wr_en", 32'(entry_wr_en), 0);
        tick();
        enq_valid = 1'b0;

        // Issue slot 2 then slot 5.
        entry_ready = 8'h04;
        issue_ready = 1'b1;
        exp_q.push_back(2);
        repeat (2) tick();
        entry_ready = 8'h20;
        exp_q.push_back(5);
        repeat (2) tick();
        entry_ready = 8'h00;
        issue_ready = 1'b0;
        at_neg();
        check("freed_occupancy", 32'(occupancy), 6);
        check("freed_enq_ready", 32'(enq_ready), 1);
        check("freed_enq_idx", 32'(enq_idx), 2);

        // Re-enqueue into 2, then 5: slot 2 is now younger than 7, 5 youngest.
        enq_valid = 1'b1;
        tick();
        at_neg();
        check("realloc_enq_idx", 32'(enq_idx), 5);
        tick();
        enq_valid = 1'b0;
        at_neg();
        check("realloc_occupancy", 32'(occupancy), 8);

        entry_ready = 8'hA4;
        issue_ready = 1'b1;
`ifdef ISQ_AGE_SELECT_OLDEST_EN
        exp_q.push_back(7);
        exp_q.push_back(2);
        exp_q.push_back(5);
`else
        exp_q.push_back(2);
        exp_q.push_back(5);
        exp_q.push_back(7);
`endif
        repeat (5) tick();
        entry_ready = 8'h00;
        issue_ready = 1'b0;
        at_neg();
        check("order_occupancy", 32'(occupancy), 5);
        check("order_issue_valid", 32'(issue_valid), 0);

        // Flush with 5 entries and one presented.
        entry_ready = 8'h01;
        tick();
        at_neg();
        check("pre_flush_valid", 32'(issue_valid), 1);
        check("pre_flush_idx", 32'(issue_idx), 0);
        flush       = 1'b1;
        issue_ready = 1'b1;
        enq_valid   = 1'b1;
        at_neg();
        check("flush_clear", 32'(entry_clear), 32'hFF);
        check("flush_enq_ready", 32'(enq_ready), 0);
        check("flush_wr_en", 32'(entry_wr_en), 0);
        tick();
        flush       = 1'b0;
        issue_ready = 1'b0;
        enq_valid   = 1'b0;
        entry_ready = 8'h00;
        at_neg();
        check("post_flush_occupancy", 32'(occupancy), 0);
        check("post_flush_valid", 32'(issue_valid), 0);
        check("post_flush_enq_idx", 32'(enq_idx), 0);

        // Single enqueue latency: enqueue at edge t, presented in cycle t+2.
        enq_valid = 1'b1;
        tick();
        enq_valid   = 1'b0;
        entry_ready = 8'h01;
        issue_ready = 1'b1;
        exp_q.push_back(0);
        at_neg();
        check("lat_t1_valid", 32'(issue_valid), 0);
        check("lat_t1_occupancy", 32'(occupancy), 1);
        tick();
        at_neg();
        check("lat_t2_valid", 32'(issue_valid), 1);
        tick();
        entry_ready = 8'h00;
        issue_ready = 1'b0;
        at_neg();
        check("lat_occupancy", 32'(occupancy), 0);
        check("lat_valid_drop", 32'(issue_valid), 0);

        // Stall: youngest (2) presented, older 0 becomes ready meanwhile.
        enq_valid = 1'b1;
        repeat (3) tick();
        enq_valid   = 1'b0;
        entry_ready = 8'h04;
        tick();
        entry_ready = 8'h05;
        for (int c = 0; c < 4; c++) begin
            at_neg();
            check("stall_valid", 32'(issue_valid), 1);
            check("stall_idx", 32'(issue_idx), 2);
            tick();
        end
        issue_ready = 1'b1;
        exp_q.push_back(2);
        exp_q.push_back(0);
        tick();
        at_neg();
        check("stall_next_idx", 32'(issue_idx), 0);
        tick();
        issue_ready = 1'b0;
        entry_ready = 8'h00;
        at_neg();
        check("stall_occupancy", 32'(occupancy), 1);
        check("stall_valid_drop", 32'(issue_valid), 0);

        // Full queue with simultaneous issue and enqueue request.
        enq_valid = 1'b1;
        repeat (7) tick();
        enq_valid = 1'b0;
        at_neg();
        check("refill_occupancy", 32'(occupancy), 8);
        entry_ready = 8'h10;
        tick();
        issue_ready = 1'b1;
        enq_valid   = 1'b1;
        exp_q.push_back(4);
        at_neg();
        check("full_issue_enq_ready", 32'(enq_ready), 0);
        check("full_issue_wr_en", 32'(entry_wr_en), 0);
        tick();
        issue_ready = 1'b0;
        entry_ready = 8'h00;
        at_neg();
        check("after_issue_enq_ready", 32'(enq_ready), 1);
        check("after_issue_enq_idx", 32'(enq_idx), 4);
        check("after_issue_occupancy", 32'(occupancy), 7);
        check("after_issue_wr_en", 32'(entry_wr_en), 32'h10);
        tick();
        enq_valid = 1'b0;
        at_neg();
        check("final_occupancy", 32'(occupancy), 8);
        check("final_enq_ready", 32'(enq_ready), 0);

        tick();
        at_neg();
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/isq_age_select.md
# isq_age_select

Allocation and oldest-first issue selector for one issue queue. Sits beside the array of `age_buffer_entry` instances:
- Upstream, it hands out free slots and drives each entry's `wr_en`.
- Downstream, it consumes every entry's `ready_to_dequeue_out`, picks the oldest ready entry, presents it on a registered valid/ready issue port and drives that entry's `clear_entry` on issue.
- Age is tracked in an internal DEPTH×DEPTH age matrix.

## Interface
- `DEPTH`, default 8: number of queue entries (2..32).
- `IDX_W`, default `$clog2(DEPTH)`: slot index width.
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `enq_valid` input 1: upstream requests allocation of one entry this cycle.
- `enq_ready` output 1: a free slot exists; `enq_valid && enq_ready` is an enqueue.
- `enq_idx` output IDX_W: lowest-index free slot; valid while `enq_ready`.
- `entry_wr_en` output DEPTH: one-hot, equals `1<<enq_idx` on enqueue, else 0.
- `entry_ready` input DEPTH: `ready_to_dequeue_out` from each entry.
- `entry_clear` output DEPTH: drives each entry's `clear_entry`.
- `issue_valid` output 1: registered; selected entry is presented.
- `issue_idx` output IDX_W: registered index of selected entry.
- `issue_ready` input 1: downstream accepts; `issue_valid && issue_ready` is an issue.
- `flush` input 1: discard every entry and any pending issue.
- `occupancy` output `$clog2(DEPTH+1)`: registered count of allocated slots.

## Operation
**Internal state**
- `occ[DEPTH]` allocated bits.
- `age[i][j]` = 1 when slot i is older than slot j.
- Issue register (`issue_valid`, `issue_idx`).

**Enqueue**
- `enq_ready = !reset && !flush && !(&occ)`.
- On enqueue to slot k at an edge: `occ[k]<=1`, `age[k][j]<=0` for all j, `age[j][k]<=occ[j]` for all j. The new entry is younger than everything allocated.

**Issue handshake**
- On issue, `entry_clear[issue_idx]=1` combinationally in the same cycle.
- At that edge `occ[issue_idx]<=0`.
- Age row/column of a freed slot are don't-care until reallocated.

**Selection**
- Candidates: `cand = entry_ready & occ & ~hold`.
- `hold` is the one-hot of `issue_idx` when `issue_valid`. A presented entry is never re-picked.
- Oldest: cand[i] with no j≠i such that cand[j] && age[j][i]. Exactly one winner when cand≠0.
- The issue register loads when `!issue_valid || issue_ready`:
  - `issue_valid <= |cand`;
  - `issue_idx <=` winner (0 if none).
- Otherwise `issue_valid`/`issue_idx` hold unchanged. A presented entry stays presented until accepted, even if an older entry becomes ready.

**Flush (priority over all)**
- `entry_clear` = all ones.
- `entry_wr_en` = 0 and no enqueue; `enq_ready=0`.
- At the edge: `occ<=0`, `issue_valid<=0`, `occupancy<=0`.
- An `issue_ready` coinciding with flush is ignored. No issue is counted.

**Occupancy**
- `occupancy <= occupancy + enq − issue`, both evaluated at the same edge.

## Timing
- Reset (synchronous): `occ=0`, `age=0`, `issue_valid=0`, `issue_idx=0`, `occupancy=0`.
- While `reset=1`: `enq_ready=0`, `entry_wr_en=0`, `entry_clear=0`.
- Enqueue→issue latency:
  - enqueue at edge t;
  - entry ready visible in cycle t+1 (conditions already set);
  - loaded at edge t+1;
  - `issue_valid=1` in cycle t+2.
- Back-to-back issue: with `issue_ready` held high and ready candidates available, one issue per cycle.
- Same-cycle enqueue and issue:
  - both take effect;
  - the slot freed by the issue is not offered by `enq_idx` until the next cycle;
  - when full, `enq_ready` rises the cycle after an issue.
- Full: `occupancy==DEPTH` forces `enq_ready=0`. Empty: `issue_valid` falls on the edge after the last issue when no candidate exists.

## Configuration
- `ISQ_AGE_SELECT_OLDEST_EN` defined: age matrix implemented, oldest-first selection as above.
- Not defined:
  - age matrix omitted;
  - winner = lowest-index bit of `cand`;
  - all other behaviour and timing identical.

## Test plan
- Reset, then enqueue 8 entries with `entry_ready` all 0 → `enq_idx` 0..7 in order, `occupancy=8`, `enq_ready=0`.
- Fill DEPTH=8, then issue slots 2 and 5. Re-enqueue into 2, then 5. Raise `entry_ready` for 2,5,7 → issue order 7,2,5 with `_OLDEST_EN`; 2,5,7 without.
- Single enqueue at edge t with `entry_ready` high from t+1 and `issue_ready=1` → `issue_valid=1` in cycle t+2, `entry_clear` one-hot same cycle, `occupancy` back to 0.
- Hold `issue_ready=0` 4 cycles while an older entry becomes ready → `issue_idx` unchanged; after accept, the older entry issues next cycle.
- Full queue with simultaneous issue and `enq_valid` → no enqueue that cycle, `enq_ready=1` next cycle, `enq_idx`=freed slot.
- Flush with 5 entries and `issue_valid=1`, `issue_ready=1` → `entry_clear=8'hFF`, next cycle `occupancy=0`, `issue_valid=0`, no issue counted.
